// File: rtl/rng_sample_fifo.sv
// Sample buffer behind the Gaussian rng: drops DISCARD warm-up samples, then
// queues samples in a show-ahead circular FIFO with a saturating drop counter.
module rng_sample_fifo #(
  parameter int BY      = 16,
  parameter int DEPTH   = 16,
  parameter int DISCARD = 4,
  parameter int CNT_BW  = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BY-1:0]     sample_in,
  input  logic              sample_valid,
  output logic [BY-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       level,
  output logic [CNT_BW-1:0] overflow_count,
  output logic              warm
);

  // Keep the counter at least one bit wide so DISCARD=0 still elaborates.
  localparam int WCW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  typedef enum logic {WARMUP, RUN} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic [AW:0]    wp, rp;
  logic [BY-1:0]  mem [DEPTH];
  logic           full, pop, push, drop;

  assign level     = wp - rp;
  assign full      = (level == (AW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = mem[rp[AW-1:0]];
  assign warm      = (state == RUN);
  assign pop       = out_valid && out_ready;
  assign push      = warm && sample_valid && (!full || pop);
  assign drop      = warm && sample_valid && full && !pop;

  // The DISCARD-th warm-up sample is itself thrown away; RUN starts after it.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    if (state == WARMUP && sample_valid) begin
      if (wcnt == WCW'(DISCARD - 1)) state_nxt = RUN;
      else                           wcnt_nxt  = wcnt + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= (DISCARD == 0) ? RUN : WARMUP;
      wcnt           <= '0;
      wp             <= '0;
      rp             <= '0;
      overflow_count <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
      if (drop && overflow_count != '1) overflow_count <= overflow_count + CNT_BW'(1);
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wp[AW-1:0]] <= sample_in;
  end

endmodule

// File: tb/tb_rng_sample_fifo.sv
// Bench for rng_sample_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_rng_sample_fifo;
  localparam int BY = 16, DEPTH = 16, DISCARD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1, sample_valid = 1'b0, out_ready = 1'b0;
  logic [BY-1:0] sample_in = '0;

  logic [BY-1:0] od, s_od, z_od;
  logic          ov, s_ov, z_ov, wm, s_wm, z_wm;
  logic [4:0]    lv, s_lv, z_lv;
  logic [15:0]   oc, z_oc;
  logic [2:0]    s_oc;

  rng_sample_fifo #(.BY(BY), .DEPTH(DEPTH), .DISCARD(DISCARD), .CNT_BW(16)) u_dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .out_data(od), .out_valid(ov), .out_ready(out_ready), .level(lv),
    .overflow_count(oc), .warm(wm));

  rng_sample_fifo #(.BY(BY), .DEPTH(DEPTH), .DISCARD(DISCARD), .CNT_BW(3)) u_sat (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .out_data(s_od), .out_valid(s_ov), .out_ready(out_ready), .level(s_lv),
    .overflow_count(s_oc), .warm(s_wm));

  rng_sample_fifo #(.BY(BY), .DEPTH(DEPTH), .DISCARD(0), .CNT_BW(16)) u_d0 (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .out_data(z_od), .out_valid(z_ov), .out_ready(out_ready), .level(z_lv),
    .overflow_count(z_oc), .warm(z_wm));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model of u_dut: queue of held samples, warm-up tally, drop tally.
  logic [BY-1:0] mq[$];
  int seen = 0, ovf = 0;

  task automatic step(input logic v, input logic [BY-1:0] d, input logic r, input logic rs);
    bit full, pop;
    sample_valid = v; sample_in = d; out_ready = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete(); seen = 0; ovf = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = r && (mq.size() != 0);
      if (pop) void'(mq.pop_front());
      if (v) begin
        if (seen < DISCARD)  seen++;
        else if (!full || pop) mq.push_back(d);
        else if (ovf < 65535) ovf++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", ov); end
    checks++; if (lv !== 5'd0) begin errors++; $display("FAIL reset_lv got %0d want 0", lv); end
    checks++; if (oc !== 16'd0) begin errors++; $display("FAIL reset_oc got %0d want 0", oc); end
    checks++; if (wm !== 1'b0) begin errors++; $display("FAIL reset_warm got %b want 0", wm); end
    checks++; if (z_wm !== 1'b1) begin errors++; $display("FAIL reset_d0_warm got %b want 1", z_wm); end
  endtask

  task automatic test_warmup();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, BY'(i), 1'b1, 1'b0);
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL warmup_ov[%0d] got %b want 0", i, ov); end
      checks++; if (wm !== (i == 4)) begin errors++; $display("FAIL warmup_warm[%0d] got %b want %b", i, wm, i == 4); end
    end
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL first_ov got %b want 1", ov); end
    checks++; if (od !== 16'h1234) begin errors++; $display("FAIL first_data got %h want 1234", od); end
    checks++; if (lv !== 5'd1) begin errors++; $display("FAIL first_lv got %0d want 1", lv); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (lv !== 5'd0) begin errors++; $display("FAIL drained_lv got %0d want 0", lv); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL drained_ov got %b want 0", ov); end
  endtask

  task automatic test_overflow();
    logic [BY-1:0] vals [20];
    for (int i = 0; i < 20; i++) begin
      vals[i] = BY'($urandom);
      step(1'b1, vals[i], 1'b0, 1'b0);
    end
    checks++; if (lv !== 5'd16) begin errors++; $display("FAIL ovf_lv got %0d want 16", lv); end
    checks++; if (oc !== 16'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", oc); end
    checks++; if (s_oc !== 3'd4) begin errors++; $display("FAIL ovf_count_sat got %0d want 4", s_oc); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (!ov || od !== vals[i]) begin errors++; $display("FAIL ovf_drain[%0d] got %b/%h want 1/%h", i, ov, od, vals[i]); end
      step(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (lv !== 5'd0) begin errors++; $display("FAIL ovf_empty_lv got %0d want 0", lv); end
  endtask

  task automatic test_back_to_back();
    logic [BY-1:0] exp[$];
    logic [BY-1:0] d;
    logic [15:0]   oc0;
    for (int i = 0; i < 16; i++) begin
      d = BY'($urandom); exp.push_back(d);
      step(1'b1, d, 1'b0, 1'b0);
    end
    oc0 = oc;
    for (int i = 0; i < 10; i++) begin
      checks++; if (od !== exp[0]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, od, exp[0]); end
      d = BY'($urandom);
      step(1'b1, d, 1'b1, 1'b0);
      void'(exp.pop_front()); exp.push_back(d);
      checks++; if (lv !== 5'd16) begin errors++; $display("FAIL b2b_lv[%0d] got %0d want 16", i, lv); end
      checks++; if (oc !== oc0) begin errors++; $display("FAIL b2b_oc[%0d] got %0d want %0d", i, oc, oc0); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (!ov || od !== exp[0]) begin errors++; $display("FAIL b2b_drain[%0d] got %b/%h want 1/%h", i, ov, od, exp[0]); end
      void'(exp.pop_front());
      step(1'b0, '0, 1'b1, 1'b0);
    end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", ov); end
  endtask

  task automatic test_saturate();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4 + 16; i++) step(1'b1, BY'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, BY'($urandom), 1'b0, 1'b0);
      if (i == 6) begin
        checks++; if (s_oc !== 3'd7) begin errors++; $display("FAIL sat_at7 got %0d want 7", s_oc); end
      end
    end
    checks++; if (s_oc !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d want 7", s_oc); end
    checks++; if (oc !== 16'd10) begin errors++; $display("FAIL sat_wide got %0d want 10", oc); end
    checks++; if (s_lv !== 5'd16) begin errors++; $display("FAIL sat_lv got %0d want 16", s_lv); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4 + 9; i++) step(1'b1, BY'($urandom), 1'b0, 1'b0);
    checks++; if (lv !== 5'd9 || wm !== 1'b1) begin errors++; $display("FAIL mid_pre got lv=%0d warm=%b want 9/1", lv, wm); end
    step(1'b1, 16'hDEAD, 1'b1, 1'b1);
    checks++; if (ov !== 1'b0 || lv !== 5'd0 || wm !== 1'b0 || oc !== 16'd0)
      begin errors++; $display("FAIL mid_reset got ov=%b lv=%0d warm=%b oc=%0d want 0/0/0/0", ov, lv, wm, oc); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, BY'($urandom), 1'b0, 1'b0);
      checks++; if (lv !== 5'd0) begin errors++; $display("FAIL mid_discard[%0d] got lv=%0d want 0", i, lv); end
    end
    checks++; if (wm !== 1'b1) begin errors++; $display("FAIL mid_warm got %b want 1", wm); end
    step(1'b1, 16'h55AA, 1'b0, 1'b0);
    checks++; if (lv !== 5'd1 || od !== 16'h55AA) begin errors++; $display("FAIL mid_push got lv=%0d data=%h want 1/55aa", lv, od); end
  endtask

  task automatic test_discard0();
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (z_wm !== 1'b1 || z_ov !== 1'b0 || z_lv !== 5'd0)
      begin errors++; $display("FAIL d0_reset got warm=%b ov=%b lv=%0d want 1/0/0", z_wm, z_ov, z_lv); end
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    checks++; if (z_ov !== 1'b1 || z_od !== 16'hBEEF || z_lv !== 5'd1)
      begin errors++; $display("FAIL d0_push got ov=%b data=%h lv=%0d want 1/beef/1", z_ov, z_od, z_lv); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL d0_main_discard got %b want 0", ov); end
  endtask

  task automatic test_random();
    int rdy_pct;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      rdy_pct = (i / 100) % 3 == 0 ? 15 : ((i / 100) % 3 == 1 ? 50 : 90);
      step($urandom_range(99) < 65, BY'($urandom), $urandom_range(99) < rdy_pct, $urandom_range(199) == 0);
      checks++; if (ov !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_ov[%0d] got %b want %b", i, ov, mq.size() != 0); end
      checks++; if (lv !== 5'(mq.size())) begin errors++; $display("FAIL rnd_lv[%0d] got %0d want %0d", i, lv, mq.size()); end
      checks++; if (wm !== (seen >= DISCARD)) begin errors++; $display("FAIL rnd_warm[%0d] got %b want %b", i, wm, seen >= DISCARD); end
      checks++; if (oc !== 16'(ovf)) begin errors++; $display("FAIL rnd_oc[%0d] got %0d want %0d", i, oc, ovf); end
      if (mq.size() != 0) begin
        checks++; if (od !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, od, mq[0]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_warmup();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_discard0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
